// File: rtl/gold_array.sv
// Gold-bag array: NUM_GOLD bags with a per-frame rest/wobble/fall/break/eaten FSM,
// merged into one registered draw request and routed digger events.
module gold_array #(
   parameter int                    NUM_GOLD         = 4,
   parameter logic [10:0]           board_position_X = 11'd32,
   parameter logic [10:0]           board_position_Y = 11'd160,
   parameter logic [4*NUM_GOLD-1:0] INIT_COL         = '0,
   parameter logic [4*NUM_GOLD-1:0] INIT_ROW         = '0,
   parameter int                    WOBBLE_FRAMES    = 8,
   parameter int                    FALL_SPEED       = 4,
   parameter int                    BREAK_ROWS       = 2,
   parameter logic [10:0]           BOTTOM_Y         = 11'd416,
   parameter logic [11:0]           GOLD_COLOR       = 12'hFC0,
   parameter logic [11:0]           BROKEN_COLOR     = 12'hFF4
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     startOfFrame,
   input  logic                     collision,
   input  logic                     been_eaten,
   input  logic [NUM_GOLD-1:0]      can_fall,
   input  logic [10:0]              pixelX,
   input  logic [10:0]              pixelY,
   output logic                     gold_dr,
   output logic [11:0]              gold_RGB,
   output logic [3:0]               gold_state,
   output logic [11*NUM_GOLD-1:0]   goldTLX,
   output logic [11*NUM_GOLD-1:0]   goldTLY,
   output logic [NUM_GOLD-1:0]      falling_mask,
   output logic                     all_eaten
);

   localparam logic [2:0] ST_REST   = 3'd0;
   localparam logic [2:0] ST_WOB    = 3'd1;
   localparam logic [2:0] ST_FALL   = 3'd2;
   localparam logic [2:0] ST_EATEN  = 3'd3;
   localparam logic [2:0] ST_BROKEN = 3'd4;

   localparam int          CW         = (WOBBLE_FRAMES > 2) ? $clog2(WOBBLE_FRAMES) : 1;
   localparam logic [CW-1:0] WOB_INIT = CW'(WOBBLE_FRAMES - 1);
   localparam int          SEL_W      = (NUM_GOLD > 1) ? $clog2(NUM_GOLD) : 1;
   localparam logic [10:0] BREAK_DIST = 11'(32 * BREAK_ROWS);

   function automatic logic [10:0] init_x(input int i);
      return board_position_X + {2'b00, INIT_COL[4*i +: 4], 5'b00000};
   endfunction

   function automatic logic [10:0] init_y(input int i);
      return board_position_Y + {2'b00, INIT_ROW[4*i +: 4], 5'b00000};
   endfunction

   // Unsigned wrap-around makes pixels left of / above the bag fail the < 32 test.
   function automatic logic bag_hit(input logic [10:0] px, input logic [10:0] py,
                                    input logic [10:0] x, input logic [10:0] y,
                                    input logic [2:0] st);
      logic [10:0] dx;
      logic [10:0] dy;
      dx = px - x;
      dy = py - y;
      return (st != ST_EATEN) && (dx < 11'd32) && (dy < 11'd32);
   endfunction

   function automatic logic [10:0] fall_y(input logic [10:0] y);
      logic [11:0] s;
      s = {1'b0, y} + 12'(FALL_SPEED);
      return (s > {1'b0, BOTTOM_Y}) ? BOTTOM_Y : s[10:0];
   endfunction

   function automatic logic stop_here(input logic [10:0] y, input logic cf);
      logic [4:0] off;
      off = y[4:0] - board_position_Y[4:0];
      return (!cf && off == 5'd0) || (y == BOTTOM_Y);
   endfunction

   logic [2:0]          st_q  [NUM_GOLD];
   logic [2:0]          st_d  [NUM_GOLD];
   logic [10:0]         x_q   [NUM_GOLD];
   logic [10:0]         y_q   [NUM_GOLD];
   logic [10:0]         y_d   [NUM_GOLD];
   logic [10:0]         sy_q  [NUM_GOLD];
   logic [10:0]         sy_d  [NUM_GOLD];
   logic [CW-1:0]       cnt_q [NUM_GOLD];
   logic [CW-1:0]       cnt_d [NUM_GOLD];
   logic [NUM_GOLD-1:0] coll_q, coll_d, eat_q, eat_d;
   logic [NUM_GOLD-1:0] fm_q, fm_d;
   logic                ae_q, ae_d;
   logic                dr_q, dr_d;
   logic [11:0]         rgb_q, rgb_d;
   logic [3:0]          gst_q, gst_d;
   logic [SEL_W-1:0]    sel_q, sel_d;

   // Draw selection: scanning downwards lets the lowest-index hit win.
   always_comb begin
      dr_d  = 1'b0;
      sel_d = '0;
      gst_d = 4'd0;
      rgb_d = 12'd0;
      for (int i = NUM_GOLD - 1; i >= 0; i--) begin
         if (bag_hit(pixelX, pixelY, x_q[i], y_q[i], st_q[i])) begin
            dr_d  = 1'b1;
            sel_d = SEL_W'(i);
            gst_d = {1'b0, st_q[i]};
            rgb_d = (st_q[i] == ST_BROKEN) ? BROKEN_COLOR : GOLD_COLOR;
         end
      end
   end

   // A frame tick consumes the old latches; an event in that same cycle starts the next frame's latch.
   always_comb begin
      for (int i = 0; i < NUM_GOLD; i++) begin
         coll_d[i] = (startOfFrame ? 1'b0 : coll_q[i]) | (dr_q & collision  & (sel_q == SEL_W'(i)));
         eat_d[i]  = (startOfFrame ? 1'b0 : eat_q[i])  | (dr_q & been_eaten & (sel_q == SEL_W'(i)));
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_GOLD; i++) begin
         st_d[i]  = st_q[i];
         y_d[i]   = y_q[i];
         sy_d[i]  = sy_q[i];
         cnt_d[i] = cnt_q[i];
         if (startOfFrame) begin
            case (st_q[i])
               ST_REST: begin
                  if (can_fall[i]) begin
                     st_d[i]  = ST_WOB;
                     cnt_d[i] = WOB_INIT;
                  end
               end
               ST_WOB: begin
                  if (!can_fall[i]) begin
                     st_d[i] = ST_REST;
                  end else if (cnt_q[i] == '0) begin
                     st_d[i] = ST_FALL;
                     sy_d[i] = y_q[i];
                  end else begin
                     cnt_d[i] = cnt_q[i] - 1'b1;
                  end
               end
               ST_FALL: begin
                  y_d[i] = fall_y(y_q[i]);
                  if (stop_here(y_d[i], can_fall[i]))
                     st_d[i] = ((y_d[i] - sy_q[i]) >= BREAK_DIST) ? ST_BROKEN : ST_REST;
               end
               ST_BROKEN: begin
                  if (eat_q[i]) st_d[i] = ST_EATEN;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      ae_d = 1'b1;
      for (int i = 0; i < NUM_GOLD; i++) begin
         fm_d[i] = (st_d[i] == ST_FALL);
         ae_d    = ae_d & (st_d[i] == ST_EATEN);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < NUM_GOLD; i++) begin
            st_q[i]  <= ST_REST;
            x_q[i]   <= init_x(i);
            y_q[i]   <= init_y(i);
            sy_q[i]  <= init_y(i);
            cnt_q[i] <= '0;
         end
         coll_q <= '0;
         eat_q  <= '0;
         fm_q   <= '0;
         ae_q   <= 1'b0;
         dr_q   <= 1'b0;
         rgb_q  <= 12'd0;
         gst_q  <= 4'd0;
         sel_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_GOLD; i++) begin
            st_q[i]  <= st_d[i];
            x_q[i]   <= x_q[i];
            y_q[i]   <= y_d[i];
            sy_q[i]  <= sy_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         coll_q <= coll_d;
         eat_q  <= eat_d;
         fm_q   <= fm_d;
         ae_q   <= ae_d;
         dr_q   <= dr_d;
         rgb_q  <= rgb_d;
         gst_q  <= gst_d;
         sel_q  <= sel_d;
      end
   end

   always_comb begin
      goldTLX = '0;
      goldTLY = '0;
      for (int i = 0; i < NUM_GOLD; i++) begin
         goldTLX[11*i +: 11] = x_q[i];
         goldTLY[11*i +: 11] = y_q[i];
      end
   end

   assign gold_dr      = dr_q;
   assign gold_RGB     = rgb_q;
   assign gold_state   = gst_q;
   assign falling_mask = fm_q;
   assign all_eaten    = ae_q;

endmodule

// File: tb/tb_gold_array.sv
// Bench for gold_array: directed scenarios plus random traffic, all checked every cycle
// against a frame-level behavioural model of the bags.
module tb_gold_array;
   localparam int          NG   = 2;
   localparam logic [10:0] BPX  = 11'd32;
   localparam logic [10:0] BPY  = 11'd160;
   localparam logic [10:0] BOT  = 11'd414;
   localparam int          WOB  = 8;
   localparam int          FS   = 4;
   localparam int          BR   = 2;
   localparam logic [7:0]  ICOL = 8'h55;
   localparam logic [7:0]  IROW = 8'h11;

   logic            clk = 1'b0;
   logic            resetN = 1'b0;
   logic            startOfFrame = 1'b0;
   logic            collision = 1'b0;
   logic            been_eaten = 1'b0;
   logic [NG-1:0]   can_fall = '0;
   logic [10:0]     pixelX = '0;
   logic [10:0]     pixelY = '0;
   logic            gold_dr;
   logic [11:0]     gold_RGB;
   logic [3:0]      gold_state;
   logic [11*NG-1:0] goldTLX, goldTLY;
   logic [NG-1:0]   falling_mask;
   logic            all_eaten;

   always #5 clk = ~clk;

   gold_array #(
      .NUM_GOLD(NG), .board_position_X(BPX), .board_position_Y(BPY),
      .INIT_COL(ICOL), .INIT_ROW(IROW), .WOBBLE_FRAMES(WOB), .FALL_SPEED(FS),
      .BREAK_ROWS(BR), .BOTTOM_Y(BOT), .GOLD_COLOR(12'hFC0), .BROKEN_COLOR(12'hFF4)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .collision(collision),
      .been_eaten(been_eaten), .can_fall(can_fall), .pixelX(pixelX), .pixelY(pixelY),
      .gold_dr(gold_dr), .gold_RGB(gold_RGB), .gold_state(gold_state),
      .goldTLX(goldTLX), .goldTLY(goldTLY), .falling_mask(falling_mask), .all_eaten(all_eaten)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_st[NG], m_y[NG], m_sy[NG], m_cnt[NG];
   bit m_coll[NG], m_eat[NG];
   int m_dr, m_sel, m_gst, m_rgb, m_fm, m_ae;

   function automatic int ix(input int i);
      return int'(BPX) + 32 * int'((ICOL >> (4 * i)) & 8'hF);
   endfunction

   function automatic int iy(input int i);
      return int'(BPY) + 32 * int'((IROW >> (4 * i)) & 8'hF);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NG; i++) begin
         m_st[i] = 0; m_y[i] = iy(i); m_sy[i] = iy(i); m_cnt[i] = 0;
         m_coll[i] = 0; m_eat[i] = 0;
      end
      m_dr = 0; m_sel = 0; m_gst = 0; m_rgb = 0; m_fm = 0; m_ae = 0;
   endtask

   task automatic m_step();
      int ndr, nsel, ngst, nrgb, ny;
      bit nc[NG];
      bit ne[NG];
      ndr = 0; nsel = 0; ngst = 0; nrgb = 0;
      for (int i = 0; i < NG; i++) begin
         if (ndr == 0 && m_st[i] != 3 &&
             ((int'(pixelX) - ix(i)) & 2047) < 32 && ((int'(pixelY) - m_y[i]) & 2047) < 32) begin
            ndr = 1; nsel = i; ngst = m_st[i]; nrgb = (m_st[i] == 4) ? 'hFF4 : 'hFC0;
         end
      end
      for (int i = 0; i < NG; i++) begin
         nc[i] = (startOfFrame ? 1'b0 : m_coll[i]) || (m_dr == 1 && collision  && m_sel == i);
         ne[i] = (startOfFrame ? 1'b0 : m_eat[i])  || (m_dr == 1 && been_eaten && m_sel == i);
      end
      if (startOfFrame) begin
         for (int i = 0; i < NG; i++) begin
            case (m_st[i])
               0: if (can_fall[i]) begin m_st[i] = 1; m_cnt[i] = WOB - 1; end
               1: if (!can_fall[i]) m_st[i] = 0;
                  else if (m_cnt[i] == 0) begin m_st[i] = 2; m_sy[i] = m_y[i]; end
                  else m_cnt[i]--;
               2: begin
                  ny = m_y[i] + FS;
                  if (ny > int'(BOT)) ny = int'(BOT);
                  m_y[i] = ny;
                  if ((!can_fall[i] && ((ny - int'(BPY)) % 32) == 0) || ny == int'(BOT))
                     m_st[i] = (ny - m_sy[i] >= 32 * BR) ? 4 : 0;
               end
               4: if (m_eat[i]) m_st[i] = 3;
               default: ;
            endcase
         end
      end
      m_fm = 0; m_ae = 1;
      for (int i = 0; i < NG; i++) begin
         m_coll[i] = nc[i]; m_eat[i] = ne[i];
         if (m_st[i] == 2) m_fm |= (1 << i);
         if (m_st[i] != 3) m_ae = 0;
      end
      m_dr = ndr; m_sel = nsel; m_gst = ngst; m_rgb = nrgb;
   endtask

   always @(posedge clk or negedge resetN) begin
      if (!resetN) m_reset();
      else m_step();
   end

   always @(negedge clk) begin
      logic [11*NG-1:0] ex, ey;
      if (chk_en) begin
         for (int i = 0; i < NG; i++) begin
            ex[11*i +: 11] = 11'(ix(i));
            ey[11*i +: 11] = 11'(m_y[i]);
         end
         check("dr", gold_dr, m_dr);
         check("rgb", gold_RGB, m_rgb);
         check("state", gold_state, m_gst);
         check("tlx", goldTLX, ex);
         check("tly", goldTLY, ey);
         check("fmask", falling_mask, m_fm);
         check("alleaten", all_eaten, m_ae);
      end
   end

   // ---------------- stimulus ----------------
   bit rnd_px = 1'b0;
   bit rnd_ev = 1'b0;
   logic [10:0] fx = 11'd0;
   logic [10:0] fy = 11'd0;

   task automatic cyc(input bit sof, input bit c, input bit e);
      @(negedge clk);
      #1;
      startOfFrame = sof;
      if (rnd_px) begin
         pixelX = 11'($urandom_range(235, 180));
         pixelY = 11'($urandom_range(430, 180));
      end else begin
         pixelX = fx;
         pixelY = fy;
      end
      if (rnd_ev) begin
         collision  = ($urandom % 3 == 0);
         been_eaten = ($urandom % 3 == 0);
      end else begin
         collision  = c;
         been_eaten = e;
      end
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         cyc(1'b1, 1'b0, 1'b0);
         repeat (3) cyc(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic look(input int x, input int y);
      fx = 11'(x);
      fy = 11'(y);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      resetN = 1'b0;
      startOfFrame = 1'b0; collision = 1'b0; been_eaten = 1'b0; can_fall = '0;
      #1;
      check("rst_dr", gold_dr, 0);
      check("rst_rgb", gold_RGB, 0);
      check("rst_state", gold_state, 0);
      check("rst_fmask", falling_mask, 0);
      check("rst_alleaten", all_eaten, 0);
      check("rst_y0", goldTLY[10:0], 192);
      check("rst_y1", goldTLY[21:11], 192);
      check("rst_tlx", goldTLX, {11'd192, 11'd192});
      repeat (2) @(negedge clk);
      #1 resetN = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      do_reset();
      chk_en = 1'b1;

      // bag1 wobbles underneath bag0: bag0 keeps the draw
      can_fall = 2'b10; frames(1); look(195, 195);
      check("ovl_dr", gold_dr, 1);
      check("ovl_state", gold_state, 0);
      check("ovl_rgb", gold_RGB, 12'hFC0);
      can_fall = 2'b00; frames(1);

      // wobble abort on bag0
      can_fall = 2'b01; frames(3); look(195, 195);
      check("wob_state", gold_state, 1);
      can_fall = 2'b00; frames(1); look(195, 195);
      check("abort_state", gold_state, 0);
      check("abort_y", goldTLY[10:0], 192);

      // fall one row and rest
      can_fall = 2'b01; frames(8);
      check("prefall_mask", falling_mask, 0);
      frames(1);
      check("fall_mask", falling_mask, 1);
      check("fall_y0", goldTLY[10:0], 192);
      frames(1);
      check("fall_y1", goldTLY[10:0], 196);
      frames(6);
      check("fall_y7", goldTLY[10:0], 220);
      can_fall = 2'b00; frames(1);
      check("rest_y", goldTLY[10:0], 224);
      check("rest_mask", falling_mask, 0);
      look(200, 230);
      check("rest_dr", gold_dr, 1);
      check("rest_state", gold_state, 0);

      // bag1 falls three rows and breaks
      can_fall = 2'b10; frames(32); can_fall = 2'b00; frames(1);
      check("b1_y", goldTLY[21:11], 288);
      look(200, 300);
      check("b1_state", gold_state, 4);
      check("b1_rgb", gold_RGB, 12'hFF4);

      // bag0 falling over broken bag1 takes the events
      can_fall = 2'b01; frames(21); look(200, 292);
      check("mid_y0", goldTLY[10:0], 272);
      check("mid_mask", falling_mask, 1);
      check("mid_state", gold_state, 2);
      cyc(1'b0, 1'b1, 1'b1);
      frames(1); look(200, 310);
      check("b1_kept_dr", gold_dr, 1);
      check("b1_kept_state", gold_state, 4);
      frames(2); can_fall = 2'b00; frames(1);
      check("brk_y0", goldTLY[10:0], 288);
      check("brk_mask", falling_mask, 0);
      look(200, 290);
      check("brk_state", gold_state, 4);

      // eat bag0 then bag1
      cyc(1'b0, 1'b0, 1'b1); frames(1); look(200, 290);
      check("eat0_dr", gold_dr, 1);
      check("eat0_state", gold_state, 4);
      check("eat0_all", all_eaten, 0);
      cyc(1'b0, 1'b0, 1'b1); frames(1); look(200, 290);
      check("eat1_dr", gold_dr, 0);
      check("eat1_state", gold_state, 0);
      check("eat1_all", all_eaten, 1);

      // clamp at the bottom
      do_reset();
      can_fall = 2'b01; frames(64);
      check("clamp_mask", falling_mask, 1);
      check("clamp_y412", goldTLY[10:0], 412);
      frames(1);
      check("clamp_y", goldTLY[10:0], 414);
      check("clamp_mask0", falling_mask, 0);
      frames(2);
      check("clamp_hold", goldTLY[10:0], 414);
      look(200, 420);
      check("clamp_state", gold_state, 4);

      // asynchronous reset while falling
      do_reset();
      can_fall = 2'b01; frames(12);
      check("prerst_mask", falling_mask, 1);
      check("prerst_y", goldTLY[10:0], 204);
      do_reset();

      // random traffic
      rnd_px = 1'b1; rnd_ev = 1'b1;
      repeat (3) begin
         do_reset();
         repeat (150) begin
            for (int i = 0; i < NG; i++) can_fall[i] = ($urandom % 4 != 0);
            frames(1);
         end
      end
      rnd_px = 1'b0; rnd_ev = 1'b0;
      frames(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
